// File: rtl/pool_if.sv
// rtl/pool_if.sv - word-serial frame handshake between the CONV stage, the pool stage and its consumer
interface pool_if #(
    parameter int DATA_W = 16
);
    logic                     POOL_start;
    logic signed [DATA_W-1:0] POOL_iData;
    logic                     POOL_finish;
    logic signed [DATA_W-1:0] POOL_oData;
    logic                     POOL_busy;

    modport master (
        output POOL_start,
        output POOL_iData,
        input  POOL_finish,
        input  POOL_oData,
        input  POOL_busy
    );

    modport slave (
        input  POOL_start,
        input  POOL_iData,
        output POOL_finish,
        output POOL_oData,
        output POOL_busy
    );
endinterface

// File: rtl/pool.sv
// rtl/pool.sv - streaming 2x2 stride-1 max-pool over a buffered IN_DIM x IN_DIM frame
// Define POOL_RELU_EN to clamp every input word at zero as it is stored.
module pool #(
    parameter int DATA_W = 16,
    parameter int IN_DIM = 5
) (
    input  logic  clk,
    input  logic  reset,
    pool_if.slave bus
);
    localparam int OUT_DIM = IN_DIM - 1;
    localparam int IN_N    = IN_DIM * IN_DIM;
    localparam int OUT_N   = OUT_DIM * OUT_DIM;
    localparam int IDX_W   = $clog2(IN_N);
    localparam int OIDX_W  = (OUT_N > 1) ? $clog2(OUT_N) : 1;

    localparam logic [IDX_W-1:0] IN_LAST   = IDX_W'(IN_N - 1);
    localparam logic [IDX_W-1:0] OUT_LAST  = IDX_W'(OUT_N - 1);
    localparam logic [IDX_W-1:0] OUT_END   = IDX_W'(OUT_N);
    localparam logic [IDX_W-1:0] IN_DIM_W  = IDX_W'(IN_DIM);
    localparam logic [IDX_W-1:0] OUT_DIM_W = IDX_W'(OUT_DIM);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0]               state;
    logic [IDX_W-1:0]         idx;
    logic signed [DATA_W-1:0] in_buf  [IN_N];
    logic signed [DATA_W-1:0] out_buf [OUT_N];
    logic                     finish_q;
    logic signed [DATA_W-1:0] odata_q;

    logic [IDX_W-1:0]         win_r;
    logic [IDX_W-1:0]         win_c;
    logic [IDX_W-1:0]         tl_idx;
    logic [IDX_W-1:0]         tr_idx;
    logic [IDX_W-1:0]         bl_idx;
    logic [IDX_W-1:0]         br_idx;
    logic [OIDX_W-1:0]        oidx;
    logic signed [DATA_W-1:0] pool_max;

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
`ifdef POOL_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Window addressing is only meaningful in CALC, where idx < OUT_N.
    always_comb begin
        win_r    = idx / OUT_DIM_W;
        win_c    = idx % OUT_DIM_W;
        tl_idx   = win_r * IN_DIM_W + win_c;
        tr_idx   = tl_idx + IDX_W'(1);
        bl_idx   = tl_idx + IN_DIM_W;
        br_idx   = bl_idx + IDX_W'(1);
        oidx     = idx[OIDX_W-1:0];
        pool_max = smax(smax(in_buf[tl_idx], in_buf[tr_idx]),
                        smax(in_buf[bl_idx], in_buf[br_idx]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            finish_q <= 1'b0;
            odata_q  <= '0;
            for (int i = 0; i < IN_N; i++) in_buf[i] <= '0;
            for (int i = 0; i < OUT_N; i++) out_buf[i] <= '0;
        end else begin
            finish_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.POOL_start) begin
                        in_buf[0] <= relu(bus.POOL_iData);
                        idx       <= IDX_W'(1);
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.POOL_start) begin
                        in_buf[idx] <= relu(bus.POOL_iData);
                        if (idx == IN_LAST) begin
                            idx   <= '0;
                            state <= S_CALC;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_CALC: begin
                    out_buf[oidx] <= pool_max;
                    if (idx == OUT_LAST) begin
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_DONE: begin
                    finish_q <= 1'b1;
                    idx      <= '0;
                    state    <= S_OUT;
                end
                S_OUT: begin
                    // One extra cycle past the last word drops the bus back to zero.
                    if (idx == OUT_END) begin
                        odata_q <= '0;
                        idx     <= '0;
                        state   <= S_IDLE;
                    end else begin
                        odata_q <= out_buf[oidx];
                        idx     <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.POOL_finish = finish_q;
    assign bus.POOL_oData  = odata_q;
    assign bus.POOL_busy   = (state != S_IDLE);
endmodule

// File: tb/tb_pool.sv
// tb/tb_pool.sv - self-checking bench for pool with a frame-level max-pool model
module tb_pool;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pool_if #(.DATA_W(16)) bus ();

    pool #(.DATA_W(16), .IN_DIM(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef POOL_RELU_EN
    localparam int NEG3_EXP = 0;
`else
    localparam int NEG3_EXP = -3;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit loading = 0;
    bit active  = 0;
    int t0;
    int fin_cyc;
    int first_edge;
    int t0_prev;
    int frame [25];
    int exp_r [16];
    int got   [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model(input int f [25], output int r [16]);
        int v [25];
        int m;
        for (int i = 0; i < 25; i++) begin
            v[i] = f[i];
`ifdef POOL_RELU_EN
            if (v[i] < 0) v[i] = 0;
`endif
        end
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++) begin
                m = v[rr*5+cc];
                if (v[rr*5+cc+1] > m) m = v[rr*5+cc+1];
                if (v[(rr+1)*5+cc] > m) m = v[(rr+1)*5+cc];
                if (v[(rr+1)*5+cc+1] > m) m = v[(rr+1)*5+cc+1];
                r[rr*4+cc] = m;
            end
    endfunction

    // Expected output timing is counted from T0, the edge capturing the last word.
    initial begin
        int d, e_busy, e_fin, e_o;
        forever begin
            @(negedge clk);
            if (!reset) begin
                e_busy = loading ? 1 : 0;
                e_fin  = 0;
                e_o    = 0;
                if (bus.POOL_finish) fin_cyc = cyc;
                if (active) begin
                    d = cyc - t0;
                    if (d < 34) e_busy = 1;
                    if (d == 17) e_fin = 1;
                    if (d >= 18 && d < 34) begin
                        e_o = exp_r[d-18];
                        got[d-18] = bus.POOL_oData;
                    end
                    if (d >= 34) active = 0;
                end
                chk("finish", int'(bus.POOL_finish), e_fin);
                chk("busy", int'(bus.POOL_busy), e_busy);
                chk("odata", int'(bus.POOL_oData), e_o);
            end
        end
    end

    task automatic send_frame(input int gap_after, input int gap_len, input bit hold);
        int t_edge;
        for (int k = 0; k < 16; k++) got[k] = 99999;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            bus.POOL_start = 1'b1;
            bus.POOL_iData = 16'(frame[i]);
            t_edge = cyc + 1;
            if (i == 0) first_edge = t_edge;
            @(posedge clk);
            loading = 1;
            if (i == 24) begin
                model(frame, exp_r);
                loading = 0;
                t0      = t_edge;
                active  = 1;
            end
            if (i + 1 == gap_after)
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    bus.POOL_start = 1'b0;
                    bus.POOL_iData = 16'($urandom);
                    @(posedge clk);
                end
        end
        if (!hold) begin
            @(negedge clk);
            bus.POOL_start = 1'b0;
            bus.POOL_iData = '0;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (active && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({name, " done timeout"}, int'(active), 0);
    endtask

    task automatic ramp(input int base);
        for (int i = 0; i < 25; i++) frame[i] = base + i;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end expected finish by 100000");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        bus.POOL_start = 1'b0;
        bus.POOL_iData = '0;
        repeat (2) @(negedge clk);
        chk("reset finish", int'(bus.POOL_finish), 0);
        chk("reset odata", int'(bus.POOL_oData), 0);
        chk("reset busy", int'(bus.POOL_busy), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp 1..25, contiguous
        ramp(1);
        send_frame(0, 0, 0);
        wait_done("s1");
        chk("s1 r0", got[0], 7);
        chk("s1 r3", got[3], 10);
        chk("s1 r5", got[5], 13);
        chk("s1 r15", got[15], 25);
        chk("s1 latency", fin_cyc - first_edge, 41);

        // All -3
        for (int i = 0; i < 25; i++) frame[i] = -3;
        send_frame(0, 0, 0);
        wait_done("s2");
        chk("s2 r0", got[0], NEG3_EXP);
        chk("s2 r15", got[15], NEG3_EXP);

        // Signed extremes in the top-left window
        for (int i = 0; i < 25; i++) frame[i] = -32768;
        frame[1] = 32767;
        frame[5] = -1;
        frame[6] = 0;
        send_frame(0, 0, 0);
        wait_done("s3");
        chk("s3 r0", got[0], 32767);
        chk("s3 r1", got[1], 32767);
        chk("s3 r4", got[4], 0);

        // Three-cycle pause after word 10
        ramp(1);
        send_frame(10, 3, 0);
        wait_done("s4");
        chk("s4 latency", fin_cyc - first_edge, 44);
        chk("s4 r0", got[0], 7);
        chk("s4 r15", got[15], 25);

        // Reset in the middle of the output stream
        ramp(1);
        send_frame(0, 0, 0);
        begin
            int n = 0;
            while (!(active && (cyc - t0) >= 23) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("s5 reach r5", got[5], 13);
        end
        #2;
        reset   = 1'b1;
        active  = 0;
        loading = 0;
        #1;
        chk("s5 async finish", int'(bus.POOL_finish), 0);
        chk("s5 async odata", int'(bus.POOL_oData), 0);
        chk("s5 async busy", int'(bus.POOL_busy), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_frame(0, 0, 0);
        wait_done("s5b");
        chk("s5b r0", got[0], 7);
        chk("s5b r5", got[5], 13);
        chk("s5b r15", got[15], 25);

        // Start held through CALC/DONE/OUT, second frame back to back
        ramp(1);
        send_frame(0, 0, 1);
        do begin
            @(negedge clk);
            bus.POOL_start = 1'b1;
            bus.POOL_iData = 16'($urandom);
        end while (cyc < t0 + 33);
        t0_prev = t0;
        ramp(26);
        send_frame(0, 0, 0);
        chk("s6 accept edge", first_edge - t0_prev, 35);
        wait_done("s6");
        chk("s6 latency", fin_cyc - first_edge, 41);
        chk("s6 r0", got[0], 32);
        chk("s6 r3", got[3], 35);
        chk("s6 r4", got[4], 37);
        chk("s6 r15", got[15], 50);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
